// File: rtl/esc_pkg.sv
// Shared types and default timing for the ESC frame scheduler.
// Speed is the 11-bit throttle word handed to the pulse generators.
package esc_pkg;

  typedef logic [10:0] speed_t;

  typedef enum logic [1:0] {
    DISARMED,
    ARMING,
    ARMED
  } esc_state_t;

  localparam int FRAME_CYCLES_DEF = 1048576;
  localparam int SLEW_MAX_DEF     = 64;
  localparam int ARM_FRAMES_DEF   = 64;

endpackage

// File: rtl/esc_slew.sv
// Per-motor slew limiter: moves cur toward tgt by at most SLEW_MAX.
// Result never leaves 0..2047 since a full step is only taken short of tgt.
module esc_slew
  import esc_pkg::*;
#(
  parameter int SLEW_MAX = SLEW_MAX_DEF
) (
  input  logic [10:0] cur,
  input  logic [10:0] tgt,
  output logic [10:0] nxt
);

  localparam logic [10:0] STEP = 11'(SLEW_MAX);

  logic signed [11:0] diff;
  logic signed [11:0] lim;

  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    lim  = $signed(12'(SLEW_MAX));
    nxt  = tgt;
    if (diff > lim) begin
      nxt = cur + STEP;
    end else if (diff < -lim) begin
      nxt = cur - STEP;
    end
  end

endmodule

// File: rtl/esc_frame_sched.sv
// Frame-paced ESC speed scheduler with arming sequence and slew limit.
// Speeds and the wrt latch strobe change together once per frame.
module esc_frame_sched
  import esc_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int SLEW_MAX     = SLEW_MAX_DEF,
  parameter int ARM_FRAMES   = ARM_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spd_vld,
  input  logic [10:0] frnt_tgt,
  input  logic [10:0] bck_tgt,
  input  logic [10:0] lft_tgt,
  input  logic [10:0] rght_tgt,
  input  logic        arm_req,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        wrt,
  output logic        armed
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int AW = $clog2(ARM_FRAMES + 1);

  logic [CW-1:0] cnt;
  logic          frame_tick;
  logic [AW-1:0] arm_cnt;
  logic          arm_clr;
  logic          arm_inc;

  esc_state_t state, state_nxt;

  speed_t tgt [4];
  speed_t sh  [4];
  speed_t cur [4];
  speed_t nxt [4];

  assign frame_tick = (cnt == CW'(FRAME_CYCLES - 1));

  always_comb begin
    tgt[0] = frnt_tgt;
    tgt[1] = bck_tgt;
    tgt[2] = lft_tgt;
    tgt[3] = rght_tgt;
  end

  assign frnt_spd = cur[0];
  assign bck_spd  = cur[1];
  assign lft_spd  = cur[2];
  assign rght_spd = cur[3];

  for (genvar g = 0; g < 4; g++) begin : g_slew
    esc_slew #(
      .SLEW_MAX(SLEW_MAX)
    ) u_slew (
      .cur(cur[g]),
      .tgt(sh[g]),
      .nxt(nxt[g])
    );
  end

  always_comb begin
    state_nxt = state;
    arm_clr   = 1'b0;
    arm_inc   = 1'b0;
    unique case (state)
      DISARMED: begin
        if (arm_req) begin
          state_nxt = ARMING;
          arm_clr   = 1'b1;
        end
      end
      ARMING: begin
        if (!arm_req) begin
          state_nxt = DISARMED;
        end else if (frame_tick) begin
          arm_inc = 1'b1;
          if (arm_cnt == AW'(ARM_FRAMES - 1)) begin
            state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        if (!arm_req) begin
          state_nxt = DISARMED;
        end
      end
      default: state_nxt = DISARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DISARMED;
      cnt     <= '0;
      arm_cnt <= '0;
      wrt     <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= frame_tick ? '0 : cnt + 1'b1;
      wrt   <= frame_tick;
      armed <= (state_nxt == ARMED);
      if (arm_clr) begin
        arm_cnt <= '0;
      end else if (arm_inc) begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  // Leaving ARMED zeroes outputs immediately; slewing only runs inside ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sh[i]  <= '0;
        cur[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (spd_vld) begin
          sh[i] <= tgt[i];
        end
        if (state_nxt != ARMED) begin
          cur[i] <= '0;
        end else if (state == ARMED && frame_tick) begin
          cur[i] <= nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_esc_frame_sched.sv
// Randomized bench for esc_frame_sched against a frame-level model.
// Directed sequences cover ramps, coincident updates, disarm and reset.
module tb_esc_frame_sched;

  localparam int FC = 100;
  localparam int SM = 64;
  localparam int AF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        spd_vld;
  logic [10:0] tgt [4];
  logic        arm_req;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        wrt;
  logic        armed;

  int n_chk  = 0;
  int n_pass = 0;

  int m_phase, m_st, m_ticks;
  int m_sh  [4];
  int m_cur [4];
  int m_wrt, m_armed;

  always #5 clk = ~clk;

  esc_frame_sched #(
    .FRAME_CYCLES(FC),
    .SLEW_MAX(SM),
    .ARM_FRAMES(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spd_vld(spd_vld),
    .frnt_tgt(tgt[0]),
    .bck_tgt(tgt[1]),
    .lft_tgt(tgt[2]),
    .rght_tgt(tgt[3]),
    .arm_req(arm_req),
    .frnt_spd(frnt_spd),
    .bck_spd(bck_spd),
    .lft_spd(lft_spd),
    .rght_spd(rght_spd),
    .wrt(wrt),
    .armed(armed)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int slew_to(input int c, input int t);
    if (t - c > SM) return c + SM;
    if (c - t > SM) return c - SM;
    return t;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_st    = 0;
    m_ticks = 0;
    m_wrt   = 0;
    m_armed = 0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = 0;
      m_cur[i] = 0;
    end
  endtask

  // States: 0 disarmed, 1 arming, 2 armed.
  task automatic model_step();
    int tick, old_st;
    tick    = (m_phase == FC - 1);
    old_st  = m_st;
    m_phase = (m_phase + 1) % FC;
    if (!arm_req) begin
      m_st = 0;
    end else if (m_st == 0) begin
      m_st    = 1;
      m_ticks = 0;
    end else if (m_st == 1 && tick != 0) begin
      m_ticks++;
      if (m_ticks == AF) m_st = 2;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_st != 2) m_cur[i] = 0;
      else if (old_st == 2 && tick != 0) m_cur[i] = slew_to(m_cur[i], m_sh[i]);
    end
    if (spd_vld) begin
      for (int i = 0; i < 4; i++) m_sh[i] = int'(tgt[i]);
    end
    m_wrt   = tick;
    m_armed = (m_st == 2);
  endtask

  task automatic check_outs();
    chk("wrt", int'(wrt), m_wrt);
    chk("armed", int'(armed), m_armed);
    chk("frnt", int'(frnt_spd), m_cur[0]);
    chk("bck", int'(bck_spd), m_cur[1]);
    chk("lft", int'(lft_spd), m_cur[2]);
    chk("rght", int'(rght_spd), m_cur[3]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 4; i++) tgt[i] = 11'(v);
    spd_vld = 1'b1;
    cycle();
    spd_vld = 1'b0;
  endtask

  task automatic wait_wrt(output int v, output int n);
    v = -1;
    n = 0;
    for (int k = 0; k < 3 * FC; k++) begin
      cycle();
      n++;
      if (wrt) begin
        v = int'(frnt_spd);
        return;
      end
    end
    chk("wrt_timeout", 0, 1);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 799) == 0) arm_req = ~arm_req;
      if ($urandom_range(0, 39) == 0 ||
          (m_phase == FC - 1 && $urandom_range(0, 3) == 0)) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 3))
            0:       tgt[i] = 11'd0;
            1:       tgt[i] = 11'd2047;
            default: tgt[i] = 11'($urandom_range(0, 2047));
          endcase
        end
        spd_vld = 1'b1;
      end
      cycle();
      spd_vld = 1'b0;
    end
  endtask

  int v, n;
  int exp_up [4] = '{64, 128, 192, 200};
  int exp_dn [4] = '{136, 72, 8, 0};

  initial begin
    rst     = 1'b1;
    arm_req = 1'b0;
    spd_vld = 1'b0;
    for (int i = 0; i < 4; i++) tgt[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs();
    #1 rst = 1'b0;

    // Disarmed: wrt keeps pulsing, speeds stay zero.
    for (int k = 0; k < 5; k++) cycle();
    set_all(300);
    for (int k = 0; k < 245; k++) cycle();

    arm_req = 1'b1;
    n = 0;
    while (!armed && n < 8 * FC) begin
      cycle();
      n++;
    end
    chk("arm_reached", int'(armed), 1);
    set_all(0);
    for (int k = 0; k < 2 * FC; k++) cycle();

    set_all(200);
    for (int j = 0; j < 4; j++) begin
      wait_wrt(v, n);
      chk("ramp_up", v, exp_up[j]);
    end
    set_all(0);
    for (int j = 0; j < 4; j++) begin
      wait_wrt(v, n);
      chk("ramp_dn", v, exp_dn[j]);
    end

    // Capture coinciding with the frame tick lands one frame later.
    n = 0;
    while (m_phase != FC - 1 && n < 2 * FC) begin
      cycle();
      n++;
    end
    tgt[0]  = 11'd10;
    spd_vld = 1'b1;
    cycle();
    spd_vld = 1'b0;
    chk("coin_wrt", int'(wrt), 1);
    chk("coin_old", int'(frnt_spd), 0);
    wait_wrt(v, n);
    chk("coin_new", v, 10);

    set_all(2047);
    for (int k = 0; k < 35 * FC; k++) cycle();
    chk("full_up", int'(frnt_spd), 2047);
    set_all(0);
    for (int k = 0; k < 35 * FC; k++) cycle();
    chk("full_dn", int'(frnt_spd), 0);
    set_all(2047);
    for (int k = 0; k < 35 * FC; k++) cycle();
    arm_req = 1'b0;
    cycle();
    chk("drop_spd", int'(frnt_spd), 0);
    chk("drop_armed", int'(armed), 0);
    for (int k = 0; k < 2 * FC; k++) cycle();

    arm_req = 1'b1;
    rand_cycles(6000);

    // Async reset mid-frame discards frame progress.
    arm_req = 1'b1;
    n = 0;
    while (m_phase != 57 && n < 2 * FC) begin
      cycle();
      n++;
    end
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #2 rst = 1'b0;
    wait_wrt(v, n);
    chk("rst_wrt_gap", n, FC);

    rand_cycles(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
